// File: rtl/axilite_mmio_bridge.sv
// axilite_mmio_bridge: local strobe-based MMIO requests -> AXI4-Lite master.
// Requests are queued in a CMD_DEPTH FIFO and issued one at a time in order.
// Optional response timeout: define AXILITE_MMIO_BRIDGE_TIMEOUT_EN.
module axilite_mmio_bridge #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int CMD_DEPTH   = 4,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  lcl_wr,
   input  logic                  lcl_rd,
   input  logic [ADDR_W-1:0]     lcl_addr,
   input  logic [DATA_W-1:0]     lcl_din,
   input  logic [DATA_W/8-1:0]   lcl_wstrb,
   output logic                  lcl_busy,
   output logic                  lcl_ack,
   output logic                  lcl_dv,
   output logic                  lcl_rsp,
   output logic [DATA_W-1:0]     lcl_dout,
   output logic                  lcl_ovf,
   output logic [ADDR_W-1:0]     m_axi_awaddr,
   output logic [2:0]            m_axi_awprot,
   output logic                  m_axi_awvalid,
   input  logic                  m_axi_awready,
   output logic [DATA_W-1:0]     m_axi_wdata,
   output logic [DATA_W/8-1:0]   m_axi_wstrb,
   output logic                  m_axi_wvalid,
   input  logic                  m_axi_wready,
   input  logic [1:0]            m_axi_bresp,
   input  logic                  m_axi_bvalid,
   output logic                  m_axi_bready,
   output logic [ADDR_W-1:0]     m_axi_araddr,
   output logic [2:0]            m_axi_arprot,
   output logic                  m_axi_arvalid,
   input  logic                  m_axi_arready,
   input  logic [DATA_W-1:0]     m_axi_rdata,
   input  logic [1:0]            m_axi_rresp,
   input  logic                  m_axi_rvalid,
   output logic                  m_axi_rready
);
   localparam int STRB_W = DATA_W/8;
   localparam int PTR_W  = $clog2(CMD_DEPTH);
   localparam logic [PTR_W:0] BUSY_AT = (PTR_W+1)'(CMD_DEPTH-2);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WADDR = 3'd1;
   localparam logic [2:0] S_WRESP = 3'd2;
   localparam logic [2:0] S_RADDR = 3'd3;
   localparam logic [2:0] S_RDATA = 3'd4;

   if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH-1)) != 0 ||
       (DATA_W != 32 && DATA_W != 64) || TIMEOUT_CYC < 1) begin : g_bad_param
      $error("axilite_mmio_bridge: illegal parameter set");
   end

   typedef struct packed {
      logic              rd;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic [STRB_W-1:0] strb;
   } cmd_t;

   cmd_t              mem [CMD_DEPTH];
   logic [PTR_W:0]    wptr, rptr, count, rd_slot, n_push;
   logic              wr_push, rd_push, empty, pop;
   cmd_t              head;
   logic [2:0]        state;
   logic              aw_done, w_done, run;
   logic [ADDR_W-1:0] cur_addr;
   logic [DATA_W-1:0] cur_data;
   logic [STRB_W-1:0] cur_strb;
   logic              aw_hs, w_hs, b_hs, r_hs, resp_hs;
   logic              tmo_hit, tmo_wr, tmo_rd;

   assign count    = wptr - rptr;
   assign empty    = (count == '0);
   assign lcl_busy = (count > BUSY_AT);
   assign wr_push  = lcl_wr && !lcl_busy;
   assign rd_push  = lcl_rd && !lcl_busy;
   assign n_push   = (PTR_W+1)'(wr_push) + (PTR_W+1)'(rd_push);
   // a read arriving alongside a write lands in the slot after it
   assign rd_slot  = wr_push ? wptr + (PTR_W+1)'(1) : wptr;
   assign head     = mem[rptr[PTR_W-1:0]];
   assign pop      = (state == S_IDLE) && !empty;

   // run stays low through reset so the readies are forced to 0
   assign m_axi_awvalid = (state == S_WADDR) && !aw_done;
   assign m_axi_wvalid  = (state == S_WADDR) && !w_done;
   assign m_axi_arvalid = (state == S_RADDR);
   assign m_axi_bready  = run && (state == S_WRESP || state == S_IDLE);
   assign m_axi_rready  = run && (state == S_RDATA || state == S_IDLE);
   assign m_axi_awaddr  = cur_addr;
   assign m_axi_araddr  = cur_addr;
   assign m_axi_wdata   = cur_data;
   assign m_axi_wstrb   = cur_strb;
   assign m_axi_awprot  = 3'b000;
   assign m_axi_arprot  = 3'b000;

   assign aw_hs   = m_axi_awvalid && m_axi_awready;
   assign w_hs    = m_axi_wvalid && m_axi_wready;
   assign b_hs    = (state == S_WRESP) && m_axi_bvalid && m_axi_bready;
   assign r_hs    = (state == S_RDATA) && m_axi_rvalid && m_axi_rready;
   assign resp_hs = b_hs || r_hs;
   // a genuine response in the expiry cycle wins over the timeout
   assign tmo_wr  = tmo_hit && !resp_hs && (state == S_WADDR || state == S_WRESP);
   assign tmo_rd  = tmo_hit && !resp_hs && (state == S_RADDR || state == S_RDATA);

`ifdef AXILITE_MMIO_BRIDGE_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYC+1);
   logic [TMO_W-1:0] tmo_cnt;
   assign tmo_hit = (state != S_IDLE) && (tmo_cnt == TMO_W'(TIMEOUT_CYC-1));

   // counts busy cycles; held at zero in IDLE so it restarts per transaction
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)              tmo_cnt <= '0;
      else if (state == S_IDLE) tmo_cnt <= '0;
      else                      tmo_cnt <= tmo_cnt + TMO_W'(1);
   end
`else
   assign tmo_hit = 1'b0;
`endif

   // queue storage; emptiness lives in the pointers, so no reset needed
   always_ff @(posedge clk) begin
      if (wr_push) mem[wptr[PTR_W-1:0]]    <= cmd_t'{1'b0, lcl_addr, lcl_din, lcl_wstrb};
      if (rd_push) mem[rd_slot[PTR_W-1:0]] <= cmd_t'{1'b1, lcl_addr, lcl_din, lcl_wstrb};
   end

   // queue pointers; push and pop may coincide
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         wptr <= wptr + n_push;
         if (pop) rptr <= rptr + (PTR_W+1)'(1);
      end
   end

   // transaction FSM: one outstanding AXI access, head of queue loaded on exit from IDLE
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= S_IDLE;
         aw_done  <= 1'b0;
         w_done   <= 1'b0;
         run      <= 1'b0;
         cur_addr <= '0;
         cur_data <= '0;
         cur_strb <= '0;
      end else begin
         run <= 1'b1;
         case (state)
            S_IDLE: if (pop) begin
               cur_addr <= head.addr;
               cur_data <= head.data;
               cur_strb <= head.strb;
               aw_done  <= 1'b0;
               w_done   <= 1'b0;
               state    <= head.rd ? S_RADDR : S_WADDR;
            end
            S_WADDR: begin
               aw_done <= aw_done || aw_hs;
               w_done  <= w_done || w_hs;
               if ((aw_done || aw_hs) && (w_done || w_hs)) state <= S_WRESP;
            end
            S_WRESP: if (b_hs) state <= S_IDLE;
            S_RADDR: if (m_axi_arready) state <= S_RDATA;
            S_RDATA: if (r_hs) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
         if (tmo_wr || tmo_rd) state <= S_IDLE;
      end
   end

   // local completion pulses, status, read data and sticky overflow
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         lcl_ack  <= 1'b0;
         lcl_dv   <= 1'b0;
         lcl_rsp  <= 1'b0;
         lcl_dout <= '0;
         lcl_ovf  <= 1'b0;
      end else begin
         lcl_ack <= b_hs || tmo_wr;
         lcl_dv  <= r_hs || tmo_rd;
         if (b_hs)                lcl_rsp <= (m_axi_bresp != 2'b00);
         else if (r_hs)           lcl_rsp <= (m_axi_rresp != 2'b00);
         else                     lcl_rsp <= tmo_wr || tmo_rd;
         if (r_hs)                lcl_dout <= m_axi_rdata;
         else if (tmo_rd)         lcl_dout <= '1;
         if ((lcl_wr || lcl_rd) && lcl_busy) lcl_ovf <= 1'b1;
      end
   end
endmodule

// File: doc/axilite_mmio_bridge.md
AXILITE_MMIO_BRIDGE -- requirements
Module: axilite_mmio_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, AXI/local address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width; legal values 32 or 64.
REQ-003 SHALL have parameter CMD_DEPTH, default 4, command queue entries; power of 2, at least 2.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 1024, response timeout in cycles.
REQ-005 SHALL have ports (clock and reset first):
- clk  in  1  clock, all logic on rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- lcl_wr, lcl_rd  in  1  one-cycle write/read request strobes.
- lcl_addr  in  ADDR_W  request address.
- lcl_din  in  DATA_W  write data.
- lcl_wstrb  in  DATA_W/8  write byte strobes.
- lcl_busy  out  1  fewer than 2 free queue entries.
- lcl_ack  out  1  write-complete pulse.
- lcl_dv  out  1  read-data-valid pulse.
- lcl_rsp  out  1  status, valid with ack/dv; 0 good, 1 error.
- lcl_dout  out  DATA_W  read data.
- lcl_ovf  out  1  sticky; a request was dropped.
- m_axi_aw*, w*, b*, ar*, r*  AXI4-Lite master, widths per parameters; awprot/arprot tied 3'b000.

Function
REQ-006 SHALL push each accepted request {type, addr, data, strb} into a FIFO of CMD_DEPTH entries.
REQ-007 SHALL, when lcl_wr and lcl_rd are high in the same cycle, enqueue both, write ahead of read.
REQ-008 SHALL drop a request arriving while lcl_busy=1, and SHALL set lcl_ovf. Queue contents SHALL remain unchanged.
REQ-009 SHALL keep one AXI transaction outstanding at a time, in queue order.
REQ-010 SHALL implement the FSM: IDLE -> WADDR (awvalid and wvalid high, each dropped independently on its own handshake) -> WRESP -> IDLE; IDLE -> RADDR -> RDATA -> IDLE.
REQ-011 SHALL leave IDLE in the cycle after the FIFO becomes non-empty. It SHALL pop the head entry on that transition.
REQ-012 SHALL keep awaddr, wdata, wstrb and araddr stable while the corresponding valid is high.
REQ-013 SHALL hold bready high only in WRESP and IDLE, and SHALL hold rready high only in RDATA and IDLE.
REQ-014 SHALL discard any b/r response handshaken in IDLE, without a local pulse.
REQ-015 SHALL pulse lcl_ack for one cycle, in the cycle after the bvalid&&bready handshake in WRESP. lcl_rsp SHALL equal (bresp!=2'b00) in that cycle.
REQ-016 SHALL pulse lcl_dv for one cycle, in the cycle after the rvalid&&rready handshake in RDATA. lcl_dout SHALL equal rdata and lcl_rsp SHALL equal (rresp!=2'b00).
REQ-017 SHALL hold lcl_dout until the next lcl_dv; lcl_rsp SHALL be 0 in all other cycles.
REQ-018 SHALL give zero-wait-slave latency for lcl_wr at cycle N into an empty queue: awvalid=wvalid=1 at N+2, bready handshake at N+3, lcl_ack at N+4. Reads SHALL follow the same timing.
REQ-019 SHALL allow push and pop in the same cycle; occupancy is unchanged and no entry is lost.

Reset
REQ-020 SHALL, on resetn low, immediately force FSM=IDLE and empty the FIFO. All outputs SHALL go to 0, including lcl_ovf, lcl_dout, all valids and all readies.
REQ-021 SHALL abandon any in-flight transaction on reset mid-operation, with no local pulse for it.

Configuration
REQ-022 SHALL compile the timeout counter in when AXILITE_MMIO_BRIDGE_TIMEOUT_EN is defined.
- The counter SHALL clear on leaving IDLE and count in every non-IDLE cycle.
- On reaching TIMEOUT_CYC it SHALL drop all valids and return to IDLE.
- It SHALL pulse lcl_ack (write) or lcl_dv (read) with lcl_rsp=1; for reads, lcl_dout SHALL be all ones.
REQ-023 SHALL, without AXILITE_MMIO_BRIDGE_TIMEOUT_EN, contain no timeout counter and wait indefinitely in each state.

Verification
REQ-024 SHALL be verified by these directed scenarios:
- Zero-wait slave; write addr 0x10, data 0xA5A5A5A5, strb 0xF at cycle 0 -> awvalid at 2, lcl_ack=1 with lcl_rsp=0 at cycle 4.
- Read addr 0x20; slave returns rdata 0x12345678, rresp=2'b10 -> lcl_dv pulse, lcl_dout=0x12345678, lcl_rsp=1.
- lcl_wr and lcl_rd in the same cycle -> AW handshake precedes AR; ack precedes dv.
- Slave stalls awready; 5 back-to-back writes with CMD_DEPTH=4 -> lcl_busy rises, dropped request sets lcl_ovf=1, exactly 3 or 4 acks per occupancy, in order.
- TIMEOUT_EN, TIMEOUT_CYC=16, read with rvalid never asserted -> lcl_dv at 16 cycles after RADDR entry, lcl_dout=all ones, lcl_rsp=1.
- resetn low while in WRESP -> all outputs 0 immediately, no lcl_ack, FIFO empty.
